// File: rtl/sync_fifo_flagged_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged_if
// Groups the FIFO's request/response/status signals into one bundle.
//   slave  modport : the FIFO itself (takes requests, drives data/status)
//   master modport : the producer/consumer side (drives requests, reads status)
// Signals:
//   flush, write_en, write_data, read_en, clr_err        : requests
//   read_data                                            : read word
//   write_full, read_empty, almost_full, almost_empty    : occupancy flags
//   count                                                : occupancy 0..DEPTH
//   overflow, underflow                                  : sticky error flags
// Handshake: a write is taken on a posedge when write_en=1 and write_full=0;
// a read is taken when read_en=1 and read_empty=0. Both flags come from the
// registered count, so a request made while the flag blocks it is dropped
// (and recorded as overflow/underflow) even if the opposite side moves in
// the same cycle. flush overrides both requests.
// ---------------------------------------------------------------------------
interface sync_fifo_flagged_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  flush;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_full;
  logic                  read_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport slave (
    input  flush, write_en, write_data, read_en, clr_err,
    output read_data, write_full, read_empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport master (
    output flush, write_en, write_data, read_en, clr_err,
    input  read_data, write_full, read_empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flagged.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged
// Single-clock FIFO with occupancy count, programmable almost-full/empty,
// sticky overflow/underflow flags, synchronous flush and an optional
// first-word-fall-through read port.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : sync_fifo_flagged_if.slave (requests in, data/status out)
// Parameters:
//   DATA_WIDTH, DEPTH (power of two, >=4), FWFT (0 = registered read with
//   one cycle latency, 1 = head of queue shown continuously),
//   AF_THRESH (almost_full when count >= it), AE_THRESH (almost_empty when
//   count <= it).
// ---------------------------------------------------------------------------
module sync_fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_flagged_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] C_AE    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_set;
  logic w_udf_set;

  // Flags decode the registered count only: no same-cycle bypass, so a
  // write while full is refused even if a read pops in the same cycle.
  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_wr_acc  = bus.write_en && !w_full  && !bus.flush;
  assign w_rd_acc  = bus.read_en  && !w_empty && !bus.flush;
  // Requests swallowed by a flush are not errors.
  assign w_ovf_set = bus.write_en && w_full  && !bus.flush;
  assign w_udf_set = bus.read_en  && w_empty && !bus.flush;

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read word: loads only on an accepted pop, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_read_data <= '0;
    else if (w_rd_acc) r_read_data <= r_mem[r_rd_ptr];
  end

  // Sticky errors: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clr_err);
      r_underflow <= w_udf_set | (r_underflow & ~bus.clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of queue is always on the port; stale but stable when empty.
      assign bus.read_data = r_mem[r_rd_ptr];
    end else begin : g_std
      assign bus.read_data = r_read_data;
    end
  endgenerate

  assign bus.count        = r_count;
  assign bus.write_full   = w_full;
  assign bus.read_empty   = w_empty;
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
module tb_sync_fifo_flagged;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;

  sync_fifo_flagged_if #(.DATA_WIDTH(8), .DEPTH(16)) a0 ();
  sync_fifo_flagged_if #(.DATA_WIDTH(8), .DEPTH(16)) a1 ();

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0),
                      .AF_THRESH(12), .AE_THRESH(4)) u_std (
    .clk(clk), .rst(rst), .bus(a0.slave));

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1),
                      .AF_THRESH(12), .AE_THRESH(4)) u_fwft (
    .clk(clk), .rst(rst), .bus(a1.slave));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    a0.flush = 0; a0.write_en = 0; a0.write_data = 0; a0.read_en = 0; a0.clr_err = 0;
    a1.flush = 0; a1.write_en = 0; a1.write_data = 0; a1.read_en = 0; a1.clr_err = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_all();

    // 1: reset with traffic present
    rst = 1'b1;
    a0.write_en = 1; a0.write_data = 8'h77; a0.read_en = 1;
    tick(); tick();
    chk("rst_count",   32'(a0.count), 0);
    chk("rst_empty",   32'(a0.read_empty), 1);
    chk("rst_aempty",  32'(a0.almost_empty), 1);
    chk("rst_full",    32'(a0.write_full), 0);
    chk("rst_afull",   32'(a0.almost_full), 0);
    chk("rst_ovf",     32'(a0.overflow), 0);
    chk("rst_udf",     32'(a0.underflow), 0);
    chk("rst_rdata",   32'(a0.read_data), 0);
    chk("rst_empty_fwft", 32'(a1.read_empty), 1);
    idle_all();
    rst = 1'b0;
    tick();
    chk("post_rst_count", 32'(a0.count), 0);

    // 2: fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      a0.write_en = 1; a0.write_data = 8'(i);
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(a0.count), 32'(i + 1));
      chk($sformatf("fill_afull_%0d", i), 32'(a0.almost_full), 32'((i + 1) >= 12));
      chk($sformatf("fill_full_%0d", i),  32'(a0.write_full), 32'((i + 1) == 16));
      chk($sformatf("fill_aempty_%0d", i), 32'(a0.almost_empty), 32'((i + 1) <= 4));
    end
    a0.write_data = 8'hAA;
    tick();
    a0.write_en = 0;
    chk("ovf_set",   32'(a0.overflow), 1);
    chk("ovf_count", 32'(a0.count), 16);
    chk("ovf_udf",   32'(a0.underflow), 0);

    // 3: drain, registered read data
    for (int i = 0; i < 16; i++) begin
      a0.read_en = 1;
      tick();
      chk($sformatf("drain_data_%0d", i),  32'(a0.read_data), 32'(i));
      chk($sformatf("drain_count_%0d", i), 32'(a0.count), 32'(15 - i));
    end
    chk("drain_empty", 32'(a0.read_empty), 1);
    tick();
    a0.read_en = 0;
    chk("udf_set",   32'(a0.underflow), 1);
    chk("udf_hold",  32'(a0.read_data), 8'h0F);
    chk("udf_ovf",   32'(a0.overflow), 1);
    chk("udf_count", 32'(a0.count), 0);
    a0.clr_err = 1;
    tick();
    a0.clr_err = 0;
    chk("clr_ovf", 32'(a0.overflow), 0);
    chk("clr_udf", 32'(a0.underflow), 0);

    // 5: FWFT instance, fall-through of a single word
    a1.write_en = 1; a1.write_data = 8'h5C;
    tick();
    a1.write_en = 0;
    chk("fwft_empty", 32'(a1.read_empty), 0);
    chk("fwft_data",  32'(a1.read_data), 8'h5C);
    chk("fwft_count", 32'(a1.count), 1);
    a1.read_en = 1;
    tick();
    a1.read_en = 0;
    chk("fwft_pop_empty", 32'(a1.read_empty), 1);
    chk("fwft_pop_udf",   32'(a1.underflow), 0);

    // 4: steady state at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      a0.write_en = 1; a0.write_data = 8'(8'h20 + i);
      exp_q.push_back(8'(8'h20 + i));
      tick();
    end
    a0.write_en = 0;
    chk("ss_count_init", 32'(a0.count), 5);
    for (int k = 0; k < 20; k++) begin
      a0.write_en = 1; a0.write_data = 8'(8'h30 + k); a0.read_en = 1;
      exp_q.push_back(8'(8'h30 + k));
      last_rd = exp_q.pop_front();
      tick();
      chk($sformatf("ss_count_%0d", k), 32'(a0.count), 5);
      chk($sformatf("ss_data_%0d", k),  32'(a0.read_data), 32'(last_rd));
    end
    a0.write_en = 0; a0.read_en = 0;

    // 6: flush at count 9 with both requests active
    for (int i = 0; i < 4; i++) begin
      a0.write_en = 1; a0.write_data = 8'(8'h50 + i);
      tick();
    end
    a0.write_en = 0;
    chk("pre_flush_count", 32'(a0.count), 9);
    a0.flush = 1; a0.write_en = 1; a0.write_data = 8'hEE; a0.read_en = 1;
    tick();
    a0.flush = 0; a0.write_en = 0; a0.read_en = 0;
    chk("flush_count", 32'(a0.count), 0);
    chk("flush_empty", 32'(a0.read_empty), 1);
    chk("flush_ovf",   32'(a0.overflow), 0);
    chk("flush_udf",   32'(a0.underflow), 0);
    chk("flush_rdata", 32'(a0.read_data), 32'(last_rd));

    // async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      a0.write_en = 1; a0.write_data = 8'(8'h60 + i);
      tick();
    end
    a0.read_en = 1;
    tick();
    chk("burst_rdata", 32'(a0.read_data), 8'h60);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(a0.count), 0);
    chk("arst_empty", 32'(a0.read_empty), 1);
    chk("arst_rdata", 32'(a0.read_data), 0);
    chk("arst_aempty", 32'(a0.almost_empty), 1);
    idle_all();
    tick();
    rst = 1'b0;
    tick();
    chk("after_arst_count", 32'(a0.count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
